// File: rtl/csr_file_pkg.sv
// Shared definitions for the machine-mode CSR file: addresses, op encodings,
// mstatus/mie bit positions and the read-modify-write helper.
package csr_file_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [11:0] CSR_MVENDORID  = 12'hF11;
    localparam logic [11:0] CSR_MARCHID    = 12'hF12;
    localparam logic [11:0] CSR_MIMPID     = 12'hF13;
    localparam logic [11:0] CSR_MHARTID    = 12'hF14;
    localparam logic [11:0] CSR_MSTATUS    = 12'h300;
    localparam logic [11:0] CSR_MISA       = 12'h301;
    localparam logic [11:0] CSR_MIE        = 12'h304;
    localparam logic [11:0] CSR_MTVEC      = 12'h305;
    localparam logic [11:0] CSR_MCOUNTEREN = 12'h306;
    localparam logic [11:0] CSR_MSCRATCH   = 12'h340;
    localparam logic [11:0] CSR_MEPC       = 12'h341;
    localparam logic [11:0] CSR_MCAUSE     = 12'h342;
    localparam logic [11:0] CSR_MTVAL      = 12'h343;
    localparam logic [11:0] CSR_MIP        = 12'h344;
    localparam logic [11:0] CSR_MCYCLE     = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET   = 12'hB02;
    localparam logic [11:0] CSR_MCYCLEH    = 12'hB80;
    localparam logic [11:0] CSR_MINSTRETH  = 12'hB82;

    typedef enum logic [1:0] {
        CSR_OP_NONE = 2'b00,
        CSR_OP_RW   = 2'b01,
        CSR_OP_RS   = 2'b10,
        CSR_OP_RC   = 2'b11
    } csr_op_e;

    localparam int unsigned MSTATUS_MIE_BIT  = 3;
    localparam int unsigned MSTATUS_MPIE_BIT = 7;
    localparam logic [XLEN-1:0] MSTATUS_MPP_MASK = 32'h0000_1800;

    localparam int unsigned MIE_MSIE_BIT = 3;
    localparam int unsigned MIE_MTIE_BIT = 7;
    localparam int unsigned MIE_MEIE_BIT = 11;
    localparam logic [XLEN-1:0] MIE_WMASK = 32'h0000_0888;

    function automatic logic [XLEN-1:0] csr_apply(csr_op_e op, logic [XLEN-1:0] old,
                                                  logic [XLEN-1:0] wdata);
        case (op)
            CSR_OP_RW: csr_apply = wdata;
            CSR_OP_RS: csr_apply = old | wdata;
            CSR_OP_RC: csr_apply = old & ~wdata;
            default:   csr_apply = old;
        endcase
    endfunction

endpackage

// File: rtl/csr_file_counter64.sv
// 64-bit free-running counter with independent 32-bit half overwrite;
// a written half replaces the incremented value, the other half keeps it.
module counter64 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en_i,
    input  logic        wr_lo_i,
    input  logic        wr_hi_i,
    input  logic [31:0] wdata_i,
    output logic [63:0] count_o
);

    logic [63:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q + 64'(en_i);
        if (wr_lo_i) cnt_d[31:0]  = wdata_i;
        if (wr_hi_i) cnt_d[63:32] = wdata_i;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign count_o = cnt_q;

endmodule

// File: rtl/csr_file.sv
// Machine-mode CSR file with trap/mret handling.
// Optional 64-bit mcycle/minstret counters when CSR_COUNTERS_EN is defined.
module csr_file
    import csr_file_pkg::*;
#(
    parameter logic [31:0] MHARTID     = 32'h0,
    parameter logic [31:0] MISA_VALUE  = 32'h4000_0100,
    parameter logic [31:0] MTVEC_RESET = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [11:0] csr_addr,
    input  logic [1:0]  csr_op,
    input  logic [31:0] csr_wdata,
    input  logic        trap_valid,
    input  logic [31:0] trap_pc,
    input  logic [31:0] trap_cause,
    input  logic [31:0] trap_val,
    input  logic        mret_valid,
    input  logic        retire,
    input  logic        irq_sw,
    input  logic        irq_timer,
    input  logic        irq_ext,
    output logic [31:0] csr_out,
    output logic        csr_illegal,
    output logic [31:0] mtvec_out,
    output logic [31:0] mepc_out,
    output logic        mstatus_mie
);

    localparam logic [31:0] MTVEC_RST = MTVEC_RESET & ~32'h3;

    logic        mie_bit_q, mie_bit_d, mpie_q, mpie_d;
    logic [31:0] mie_q, mie_d, mtvec_q, mtvec_d, mscratch_q, mscratch_d;
    logic [31:0] mepc_q, mepc_d, mcause_q, mcause_d, mtval_q, mtval_d;

    csr_op_e     op;
    logic        implemented, write_eff, write_ok;
    logic [31:0] rdata, new_val;

    assign op = csr_op_e'(csr_op);

`ifdef CSR_COUNTERS_EN
    logic [63:0] mcycle, minstret;

    counter64 u_mcycle (
        .clk     (clk),
        .rst_n   (rst_n),
        .en_i    (1'b1),
        .wr_lo_i (write_ok && csr_addr == CSR_MCYCLE),
        .wr_hi_i (write_ok && csr_addr == CSR_MCYCLEH),
        .wdata_i (new_val),
        .count_o (mcycle)
    );

    counter64 u_minstret (
        .clk     (clk),
        .rst_n   (rst_n),
        .en_i    (retire),
        .wr_lo_i (write_ok && csr_addr == CSR_MINSTRET),
        .wr_hi_i (write_ok && csr_addr == CSR_MINSTRETH),
        .wdata_i (new_val),
        .count_o (minstret)
    );
`else
    logic unused_retire;
    assign unused_retire = retire;
`endif

    // Read mux: pre-write value of the addressed CSR, no bypass.
    always_comb begin
        rdata       = '0;
        implemented = 1'b1;
        case (csr_addr)
            CSR_MVENDORID, CSR_MARCHID, CSR_MIMPID, CSR_MCOUNTEREN: rdata = '0;
            CSR_MHARTID:  rdata = MHARTID;
            CSR_MSTATUS: begin
                rdata                   = MSTATUS_MPP_MASK;
                rdata[MSTATUS_MIE_BIT]  = mie_bit_q;
                rdata[MSTATUS_MPIE_BIT] = mpie_q;
            end
            CSR_MISA:     rdata = MISA_VALUE;
            CSR_MIE:      rdata = mie_q;
            CSR_MTVEC:    rdata = mtvec_q;
            CSR_MSCRATCH: rdata = mscratch_q;
            CSR_MEPC:     rdata = mepc_q;
            CSR_MCAUSE:   rdata = mcause_q;
            CSR_MTVAL:    rdata = mtval_q;
            CSR_MIP: begin
                rdata[MIE_MSIE_BIT] = irq_sw;
                rdata[MIE_MTIE_BIT] = irq_timer;
                rdata[MIE_MEIE_BIT] = irq_ext;
            end
`ifdef CSR_COUNTERS_EN
            CSR_MCYCLE:    rdata = mcycle[31:0];
            CSR_MCYCLEH:   rdata = mcycle[63:32];
            CSR_MINSTRET:  rdata = minstret[31:0];
            CSR_MINSTRETH: rdata = minstret[63:32];
`endif
            default:      implemented = 1'b0;
        endcase
    end

    assign write_eff   = (op == CSR_OP_RW) || (op != CSR_OP_NONE && csr_wdata != '0);
    assign csr_illegal = (op != CSR_OP_NONE) &&
                         (!implemented || (csr_addr[11:10] == 2'b11 && write_eff));
    assign write_ok    = write_eff && !csr_illegal;
    assign new_val     = csr_apply(op, rdata, csr_wdata);
    assign csr_out     = rdata;

    // Next state: CSR write first, then mret, then trap override the fields they own.
    always_comb begin
        mie_bit_d  = mie_bit_q;
        mpie_d     = mpie_q;
        mie_d      = mie_q;
        mtvec_d    = mtvec_q;
        mscratch_d = mscratch_q;
        mepc_d     = mepc_q;
        mcause_d   = mcause_q;
        mtval_d    = mtval_q;

        if (write_ok) begin
            case (csr_addr)
                CSR_MSTATUS: begin
                    mie_bit_d = new_val[MSTATUS_MIE_BIT];
                    mpie_d    = new_val[MSTATUS_MPIE_BIT];
                end
                CSR_MIE:      mie_d      = new_val & MIE_WMASK;
                CSR_MTVEC:    mtvec_d    = new_val & ~32'h3;
                CSR_MSCRATCH: mscratch_d = new_val;
                CSR_MEPC:     mepc_d     = new_val & ~32'h3;
                CSR_MCAUSE:   mcause_d   = new_val;
                CSR_MTVAL:    mtval_d    = new_val;
                default: ;
            endcase
        end

        if (trap_valid) begin
            mepc_d    = trap_pc & ~32'h3;
            mcause_d  = trap_cause;
            mtval_d   = trap_val;
            mpie_d    = mie_bit_q;
            mie_bit_d = 1'b0;
        end else if (mret_valid) begin
            mie_bit_d = mpie_q;
            mpie_d    = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mie_bit_q  <= 1'b0;
            mpie_q     <= 1'b0;
            mie_q      <= '0;
            mtvec_q    <= MTVEC_RST;
            mscratch_q <= '0;
            mepc_q     <= '0;
            mcause_q   <= '0;
            mtval_q    <= '0;
        end else begin
            mie_bit_q  <= mie_bit_d;
            mpie_q     <= mpie_d;
            mie_q      <= mie_d;
            mtvec_q    <= mtvec_d;
            mscratch_q <= mscratch_d;
            mepc_q     <= mepc_d;
            mcause_q   <= mcause_d;
            mtval_q    <= mtval_d;
        end
    end

    assign mtvec_out   = mtvec_q;
    assign mepc_out    = mepc_q;
    assign mstatus_mie = mie_bit_q;

endmodule
